wb_commit_buf: RTL
==================

# wb_commit_buf

Parametrised writeback/commit stage for the RV32I pipeline. It sits between the MEM stage and the register file. It buffers up to DEPTH in-flight instructions, so the MEM stage does not stall while loads wait on the data memory. Each load's response is aligned and sign- or zero-extended into its entry, and instructions commit to the register file strictly in program order, at most one per cycle, with a running retire-order count.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- DEPTH, 4, buffer entries; power of two, ≥2.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  buffer can accept: count < DEPTH and !rst.
- in_we  in  1  instruction writes rd.
- in_rd  in  5  destination register.
- in_kind  in  3  0=pass, 1=lb, 2=lbu, 3=lh, 4=lhu, 5=lw; 6 and 7 are illegal and treated as pass.
- in_data  in  XLEN  result for pass kind; ignored for loads.
- in_addr_lo  in  2  load byte offset (addr[1:0]).
- dmem_resp  in  1  load data valid.
- dmem_rdata  in  32  raw word for the oldest pending load.
- regf_we  out  1  register-file write enable.
- rd_sel  out  5  register-file write index.
- rd_v  out  XLEN  register-file write data.
- commit_valid  out  1  one instruction retired this cycle.
- commit_order  out  64  retire index of that instruction, starting at 0.
- byp_rs, byp_hit, byp_stall, byp_v: present only under WB_BYPASS_EN (see Configuration).

## Operation
- Storage is a circular FIFO with head/tail pointers of width log2(DEPTH) and a count of width log2(DEPTH)+1.
  - Each entry holds we, rd, kind, addr_lo, data and a ready bit.
  - Pointers wrap modulo DEPTH.
- Enqueue occurs when in_valid && in_ready.
  - Pass-kind entries are ready at enqueue.
  - Load entries enqueue with ready=0 (pending).
- Load responses:
  - A dmem_resp fills the oldest pending entry, searched from head.
  - Extension is applied at fill time:
    - lb/lbu: byte at rdata[8*lo +: 8].
    - lh/lhu: halfword at rdata[16*lo[1] +: 16].
    - lw: the whole word.
    - Signed kinds replicate the MSB; unsigned kinds zero-fill.
  - A dmem_resp with no pending entry is ignored.
  - A response can never target an entry enqueued in the same cycle.
- Commit:
  - When the head entry is ready, it dequeues.
  - Fast path: the head is a pending load and dmem_resp is high; it fills and dequeues in the same cycle.
  - The registered outputs are then set for the following cycle:
    - commit_valid=1 and commit_order=ctr.
    - regf_we = we && rd!=0.
    - rd_sel = rd and rd_v = data when regf_we=1; both are 0 otherwise.
  - ctr is incremented by 1 on each commit; it wraps at 2^64.
- When no commit occurs, the next cycle's outputs are regf_we=0, rd_sel=0, rd_v=0 and commit_valid=0. commit_order holds its last value.
- A load with rd=0 still waits for its response. It retires with commit_valid=1 and regf_we=0.
- Enqueue and dequeue may occur in the same cycle; count is then unchanged. When full, in_ready=0 even if the head commits that cycle; there is no combinational ready credit.
- Reset:
  - Pointers, count, ctr and all ready bits are cleared.
  - All outputs are 0 in the cycle after rst is sampled high, and in_ready=0 while rst=1.
  - Reset mid-operation discards every entry, including pending loads.
  - A dmem_resp arriving while rst=1, or before any load has enqueued afterwards, is ignored.

## Timing
- Pass instruction accepted in cycle N into an empty buffer: commit outputs in cycle N+2.
- Load at the head with dmem_resp in cycle M: commit outputs in cycle M+1.
- A load that is not at the head becomes ready on its response. It commits one cycle after every older entry has committed.
- Throughput: one commit per cycle; back-to-back ready entries commit in consecutive cycles.
- in_ready is combinational from count and rst only.

## Configuration
- WB_BYPASS_EN defined: adds input byp_rs[4:0] and outputs byp_hit, byp_stall and byp_v[XLEN-1:0]. All three outputs are combinational.
  - The block finds the youngest valid entry with we=1 and rd==byp_rs, ignoring byp_rs==0.
  - If that entry is ready: byp_hit=1, byp_v is its data, byp_stall=0.
  - If that entry is pending: byp_stall=1 and byp_hit=0.
  - If no entry matches: byp_hit=0, byp_stall=0, byp_v=0.
- WB_BYPASS_EN undefined: these ports and the search logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then pass rd=1/2/3 with data 0x11/0x22/0x33 on consecutive cycles from N → commits in N+2, N+3 and N+4 with orders 0, 1, 2 and regf_we=1.
- lb with lo=3, then lhu with lo=2, against rdata 0x80FF_FF01 and 0x8001_1234 → rd_v=0xFFFF_FF80, then 0x0000_8001.
- Load rd=4 followed by pass rd=5, with the response delayed to cycle M → load commits in M+1 and the pass commits in M+2; no commit occurs before M+1.
- DEPTH=4 pending loads → in_ready=0. One response → in_ready=1 in the cycle after the head dequeues. A stray dmem_resp on an empty buffer → no state change.
- Pass with we=1, rd=0, data 0xDEAD → commit_valid=1, regf_we=0, rd_sel=0, rd_v=0. Assert rst with 3 entries held → all outputs 0 next cycle and orders restart at 0.
- WB_BYPASS_EN: pending load rd=5 with byp_rs=5 → byp_stall=1. Then add a younger pass rd=5 with data 0x55 → byp_hit=1, byp_v=0x55, byp_stall=0.

Source files
------------

// File: rtl/wb_commit_buf.sv
`default_nettype none
// ============================================================================
// Module      : wb_commit_buf
// Description : Writeback/commit buffer for the RV32I pipeline. Holds up to
//               DEPTH in-flight instructions between MEM and the register
//               file. It aligns and extends load responses into their
//               entries, and it retires entries in program order at one
//               per cycle. Each retire carries a 64-bit retire index.
//
// Ports       : clk, rst          - clock (rising edge), sync active-high reset
//               in_valid/in_ready - enqueue handshake from the MEM stage
//               in_we, in_rd      - destination write enable and index
//               in_kind           - 0 pass, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw
//               in_data           - result for pass-kind instructions
//               in_addr_lo        - byte offset of a load
//               dmem_resp/rdata   - load response for the oldest pending load
//               regf_we, rd_sel, rd_v - registered register-file write port
//               commit_valid, commit_order - registered retire indication
//
// Options     : Define WB_BYPASS_EN to add the forwarding search ports
//               byp_rs (in), byp_hit, byp_stall, byp_v (combinational out).
//
// Revision    : 1.0 - initial release
// ============================================================================
module wb_commit_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_we,
    input  logic [4:0]      in_rd,
    input  logic [2:0]      in_kind,
    input  logic [XLEN-1:0] in_data,
    input  logic [1:0]      in_addr_lo,
    input  logic            dmem_resp,
    input  logic [31:0]     dmem_rdata,
    output logic            regf_we,
    output logic [4:0]      rd_sel,
    output logic [XLEN-1:0] rd_v,
    output logic            commit_valid,
    output logic [63:0]     commit_order
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]      byp_rs,
    output logic            byp_hit,
    output logic            byp_stall,
    output logic [XLEN-1:0] byp_v
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] c_KIND_LB  = 3'd1;
    localparam logic [2:0] c_KIND_LBU = 3'd2;
    localparam logic [2:0] c_KIND_LH  = 3'd3;
    localparam logic [2:0] c_KIND_LHU = 3'd4;
    localparam logic [2:0] c_KIND_LW  = 3'd5;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] ent_we_q;
    logic [DEPTH-1:0] ent_rdy_q;
    logic [4:0]       ent_rd_q   [DEPTH];
    logic [2:0]       ent_kind_q [DEPTH];
    logic [1:0]       ent_lo_q   [DEPTH];
    logic [XLEN-1:0]  ent_data_q [DEPTH];

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [63:0]      ctr_q, ctr_d;

    logic             cv_q, cv_d;
    logic             rwe_q, rwe_d;
    logic [4:0]       rsel_q, rsel_d;
    logic [XLEN-1:0]  rv_q, rv_d;
    logic [63:0]      ord_q, ord_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic             w_enq;
    logic             w_in_is_load;
    logic             w_pend_found;
    logic [AW-1:0]    w_pend_idx;
    logic             w_fill;
    logic [XLEN-1:0]  w_fill_data;
    logic             w_fast;
    logic             w_deq;
    logic [XLEN-1:0]  w_head_data;
    logic             w_head_we;

    assign in_ready     = !rst && (count_q < CW'(DEPTH));
    assign w_enq        = in_valid && in_ready;
    assign w_in_is_load = (in_kind >= c_KIND_LB) && (in_kind <= c_KIND_LW);

    // Oldest pending entry, scanning from head over live entries only.
    always_comb begin
        logic [AW-1:0] v_idx;
        w_pend_found = 1'b0;
        w_pend_idx   = '0;
        v_idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = head_q + AW'(i);
            if (!w_pend_found && (CW'(i) < count_q) && !ent_rdy_q[v_idx]) begin
                w_pend_found = 1'b1;
                w_pend_idx   = v_idx;
            end
        end
    end

    // Alignment and extension of the response for the targeted entry.
    always_comb begin
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        v_byte = dmem_rdata[{ent_lo_q[w_pend_idx], 3'b000} +: 8];
        v_half = dmem_rdata[{ent_lo_q[w_pend_idx][1], 4'b0000} +: 16];
        case (ent_kind_q[w_pend_idx])
            c_KIND_LB:  w_fill_data = {{(XLEN-8){v_byte[7]}}, v_byte};
            c_KIND_LBU: w_fill_data = {{(XLEN-8){1'b0}}, v_byte};
            c_KIND_LH:  w_fill_data = {{(XLEN-16){v_half[15]}}, v_half};
            c_KIND_LHU: w_fill_data = {{(XLEN-16){1'b0}}, v_half};
            default:    w_fill_data = dmem_rdata;
        endcase
    end

    assign w_fill = dmem_resp && w_pend_found;

    // A pending head can only be the oldest pending entry, so a fill that
    // targets the head index lets it retire in the same cycle.
    assign w_fast      = w_fill && (w_pend_idx == head_q);
    assign w_deq       = (count_q != '0) && (ent_rdy_q[head_q] || w_fast);
    assign w_head_data = w_fast ? w_fill_data : ent_data_q[head_q];
    assign w_head_we   = ent_we_q[head_q] && (ent_rd_q[head_q] != 5'd0);

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ctr_d   = ctr_q;
        cv_d    = 1'b0;
        rwe_d   = 1'b0;
        rsel_d  = 5'd0;
        rv_d    = '0;
        ord_d   = ord_q;

        if (w_deq) begin
            head_d = head_q + AW'(1);
            cv_d   = 1'b1;
            ord_d  = ctr_q;
            ctr_d  = ctr_q + 64'd1;
            if (w_head_we) begin
                rwe_d  = 1'b1;
                rsel_d = ent_rd_q[head_q];
                rv_d   = w_head_data;
            end
        end

        if (w_enq) begin
            tail_d = tail_q + AW'(1);
        end

        case ({w_enq, w_deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Control state and ready bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ctr_q     <= '0;
            ent_rdy_q <= '0;
            cv_q      <= 1'b0;
            rwe_q     <= 1'b0;
            rsel_q    <= 5'd0;
            rv_q      <= '0;
            ord_q     <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ctr_q   <= ctr_d;
            cv_q    <= cv_d;
            rwe_q   <= rwe_d;
            rsel_q  <= rsel_d;
            rv_q    <= rv_d;
            ord_q   <= ord_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_fill && (w_pend_idx == AW'(i))) begin
                    ent_rdy_q[i] <= 1'b1;
                end
            end
            // The tail slot is free, so it never collides with a fill target.
            if (w_enq) begin
                ent_rdy_q[tail_q] <= !w_in_is_load;
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry payload (no reset needed: validity comes from count/ready)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_fill && (w_pend_idx == AW'(i))) begin
                    ent_data_q[i] <= w_fill_data;
                end
            end
            if (w_enq) begin
                ent_we_q[tail_q]   <= in_we;
                ent_rd_q[tail_q]   <= in_rd;
                ent_kind_q[tail_q] <= in_kind;
                ent_lo_q[tail_q]   <= in_addr_lo;
                ent_data_q[tail_q] <= in_data;
            end
        end
    end

    assign regf_we      = rwe_q;
    assign rd_sel       = rsel_q;
    assign rd_v         = rv_q;
    assign commit_valid = cv_q;
    assign commit_order = ord_q;

`ifdef WB_BYPASS_EN
    // ------------------------------------------------------------------
    // Forwarding search: youngest live entry writing byp_rs.
    // ------------------------------------------------------------------
    logic          w_bm_found;
    logic [AW-1:0] w_bm_idx;

    always_comb begin
        logic [AW-1:0] v_idx;
        w_bm_found = 1'b0;
        w_bm_idx   = '0;
        v_idx      = '0;
        // Later iterations are younger, so the last match wins.
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = head_q + AW'(i);
            if ((CW'(i) < count_q) && ent_we_q[v_idx] && (ent_rd_q[v_idx] == byp_rs)) begin
                w_bm_found = 1'b1;
                w_bm_idx   = v_idx;
            end
        end
    end

    always_comb begin
        byp_hit   = 1'b0;
        byp_stall = 1'b0;
        byp_v     = '0;
        if (w_bm_found && (byp_rs != 5'd0)) begin
            if (ent_rdy_q[w_bm_idx]) begin
                byp_hit = 1'b1;
                byp_v   = ent_data_q[w_bm_idx];
            end else begin
                byp_stall = 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
